// File: rtl/sensor_log_ctrl.sv
// sensor_log_ctrl: logs ADC samples into per-channel circular memory regions.
// Serial read-out on bit_clk; define SENSLOG_POP_ON_READ_EN for FIFO pop.
module sensor_log_ctrl #(
  parameter int NUM_CH    = 3,
  parameter int ADC_W     = 8,
  parameter int ADDR_W    = 6,
  parameter int CH_DEPTH  = 16,
  parameter int BASE_ADDR = 16,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int IDX_W = $clog2(CH_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              adc_valid,
  output logic              adc_ready,
  input  logic [CH_W-1:0]   adc_ch,
  input  logic [ADC_W-1:0]  adc_data,
  input  logic [7:0]        time_stamp,
  input  logic              rd_req,
  input  logic [CH_W-1:0]   rd_ch,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_busy,
  output logic              rd_empty,
  input  logic              bit_clk,
  output logic              bit_out,
  output logic              rd_done,
  input  logic [15:0]       mem_read_in,
  output logic [15:0]       mem_data_out,
  output logic [ADDR_W-1:0] mem_address,
  output logic              PC_B,
  output logic              WE,
  output logic              SE,
  output logic [NUM_CH-1:0] ovf
);

`ifdef SENSLOG_POP_ON_READ_EN
  localparam bit POP = 1'b1;
`else
  localparam bit POP = 1'b0;
`endif

  localparam logic [CH_W:0]     NCH  = (CH_W+1)'(NUM_CH);
  localparam logic [IDX_W:0]    FULL = (IDX_W+1)'(CH_DEPTH);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  typedef enum logic [2:0] {
    IDLE, W_PRE, W_WR, R_PRE, R_SE, SHIFT
  } state_t;

  state_t state, nxt;

  logic [IDX_W-1:0]  wptr [NUM_CH];
  logic [IDX_W:0]    count [NUM_CH];
  logic [CH_W-1:0]   wch, rch;
  logic              pop;
  logic [15:0]       shift;
  logic [3:0]        bcnt;
  logic              bclk_r, bclk_d, bclk_edge;
  logic              wr_ok, rch_ok, rd_ok;
  logic              wr_go, rd_go;
  logic [CH_W-1:0]   wci, rci;
  logic [IDX_W-1:0]  ridx;
  logic [15:0]       word;
  logic [ADDR_W-1:0] wr_addr, rd_addr;

  assign wr_ok  = {1'b0, adc_ch} < NCH;
  assign rch_ok = {1'b0, rd_ch} < NCH;
  assign wci    = wr_ok ? adc_ch : '0;
  assign rci    = rch_ok ? rd_ch : '0;
  assign rd_ok  = rch_ok && ({1'b0, rd_idx} < count[rci]);

  // oldest entry sits count slots behind the write pointer
  assign ridx = wptr[rci] - count[rci][IDX_W-1:0] + rd_idx;

  assign word = ({8'h00, time_stamp} << ADC_W)
              | {{(16-ADC_W){1'b0}}, adc_data};

  assign wr_addr = BASE + (ADDR_W'(wci) << IDX_W)
                 + ADDR_W'(wptr[wci]);
  assign rd_addr = BASE + (ADDR_W'(rci) << IDX_W)
                 + ADDR_W'(ridx);

  assign bclk_edge = bclk_r & ~bclk_d;
  assign bit_out   = shift[15];

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt       = state;
    adc_ready = 1'b0;
    rd_busy   = 1'b0;
    PC_B      = 1'b1;
    WE        = 1'b0;
    SE        = 1'b0;
    wr_go     = 1'b0;
    rd_go     = 1'b0;
    unique case (state)
      IDLE: begin
        adc_ready = ~rd_req & reset;
        if (rd_req) begin
          rd_go = 1'b1;
          nxt   = rd_ok ? R_PRE : SHIFT;
        end else if (adc_valid && wr_ok) begin
          wr_go = 1'b1;
          nxt   = W_PRE;
        end
      end
      W_PRE: begin
        PC_B = 1'b0;
        nxt  = W_WR;
      end
      W_WR: begin
        WE  = 1'b1;
        nxt = IDLE;
      end
      R_PRE: begin
        PC_B    = 1'b0;
        rd_busy = 1'b1;
        nxt     = R_SE;
      end
      R_SE: begin
        SE      = 1'b1;
        rd_busy = 1'b1;
        nxt     = SHIFT;
      end
      SHIFT: begin
        rd_busy = 1'b1;
        if (bclk_edge && bcnt == 4'hF) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_address  <= '0;
      mem_data_out <= '0;
      rd_empty     <= 1'b0;
      rd_done      <= 1'b0;
      ovf          <= '0;
      wch          <= '0;
      rch          <= '0;
      pop          <= 1'b0;
      shift        <= '0;
      bcnt         <= '0;
      bclk_r       <= 1'b0;
      bclk_d       <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        wptr[i]  <= '0;
        count[i] <= '0;
      end
    end else begin
      bclk_r  <= bit_clk;
      bclk_d  <= bclk_r;
      rd_done <= 1'b0;
      if (wr_go) begin
        wch          <= adc_ch;
        mem_address  <= wr_addr;
        mem_data_out <= word;
      end
      if (rd_go) begin
        rd_empty <= ~rd_ok;
        rch      <= rd_ch;
        pop      <= (rd_idx == '0);
        bcnt     <= '0;
        if (rd_ok) mem_address <= rd_addr;
        else       shift <= '0;
      end
      if (state == W_WR) begin
        wptr[wch] <= wptr[wch] + IDX_W'(1);
        if (count[wch] == FULL) ovf[wch] <= 1'b1;
        else count[wch] <= count[wch] + (IDX_W+1)'(1);
      end
      if (state == R_SE) begin
        shift <= mem_read_in;
        if (POP && pop)
          count[rch] <= count[rch] - (IDX_W+1)'(1);
      end
      if (state == SHIFT && bclk_edge) begin
        shift <= {shift[14:0], 1'b0};
        bcnt  <= bcnt + 4'd1;
        if (bcnt == 4'hF) rd_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sensor_log_ctrl.sv
// tb_sensor_log_ctrl: directed bench with a queue-based logging model
// and a word-memory model behind the strobes.
module tb_sensor_log_ctrl;

  localparam int BASE  = 16;
  localparam int DEPTH = 16;
`ifdef SENSLOG_POP_ON_READ_EN
  localparam bit POP = 1'b1;
`else
  localparam bit POP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        adc_valid;
  logic        adc_ready;
  logic [1:0]  adc_ch;
  logic [7:0]  adc_data;
  logic [7:0]  time_stamp;
  logic        rd_req;
  logic [1:0]  rd_ch;
  logic [3:0]  rd_idx;
  logic        rd_busy;
  logic        rd_empty;
  logic        bit_clk;
  logic        bit_out;
  logic        rd_done;
  logic [15:0] mem_read_in;
  logic [15:0] mem_data_out;
  logic [5:0]  mem_address;
  logic        PC_B, WE, SE;
  logic [2:0]  ovf;

  always #5 clk = ~clk;

  sensor_log_ctrl #(
    .NUM_CH(3), .ADC_W(8), .ADDR_W(6),
    .CH_DEPTH(DEPTH), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .reset(reset),
    .adc_valid(adc_valid), .adc_ready(adc_ready),
    .adc_ch(adc_ch), .adc_data(adc_data),
    .time_stamp(time_stamp),
    .rd_req(rd_req), .rd_ch(rd_ch), .rd_idx(rd_idx),
    .rd_busy(rd_busy), .rd_empty(rd_empty),
    .bit_clk(bit_clk), .bit_out(bit_out), .rd_done(rd_done),
    .mem_read_in(mem_read_in), .mem_data_out(mem_data_out),
    .mem_address(mem_address),
    .PC_B(PC_B), .WE(WE), .SE(SE), .ovf(ovf)
  );

  logic [15:0] mem [64];
  assign mem_read_in = mem[mem_address];
  always @(posedge clk) if (WE) mem[mem_address] <= mem_data_out;

  typedef logic [15:0] wq_t [$];
  wq_t        mq [3];
  int         wcnt [3];
  logic [2:0] m_ovf;

  int ntests = 0;
  int nfail = 0;
  int done_cnt = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) if (rd_done) done_cnt++;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_ovf", ovf, m_ovf);
      chk("cyc_strobe", {WE & SE, WE & ~PC_B, SE & ~PC_B,
                         rd_busy & adc_ready}, 0);
    end
  end

  task automatic model_clear();
    for (int c = 0; c < 3; c++) begin
      mq[c].delete();
      wcnt[c] = 0;
    end
    m_ovf = '0;
  endtask

  task automatic do_write(input int ch, input logic [7:0] d,
                          input logic [7:0] ts);
    int n;
    int ea;
    adc_ch = 2'(ch);
    adc_data = d;
    time_stamp = ts;
    adc_valid = 1'b1;
    n = 0;
    while (!adc_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("w_ready", adc_ready, 1);
    @(posedge clk); #1;
    adc_valid = 1'b0;
    if (ch < 3) begin
      ea = BASE + ch * DEPTH + (wcnt[ch] % DEPTH);
      chk("w_pre_pcb", PC_B, 0);
      chk("w_pre_we", WE, 0);
      chk("w_addr", mem_address, ea);
      chk("w_data", mem_data_out, {ts, d});
      @(posedge clk); #1;
      chk("w_wr_pcb", PC_B, 1);
      chk("w_wr_we", WE, 1);
      @(posedge clk); #1;
      chk("w_end_we", WE, 0);
      chk("w_end_ready", adc_ready, 1);
      if (mq[ch].size() == DEPTH) begin
        void'(mq[ch].pop_front());
        m_ovf[ch] = 1'b1;
      end
      mq[ch].push_back({ts, d});
      wcnt[ch]++;
    end else begin
      chk("w_drop_pcb", PC_B, 1);
      chk("w_drop_ready", adc_ready, 1);
    end
  endtask

  task automatic do_read(input int ch, input int idx, input bit with_adc,
                         output logic [15:0] got);
    bit vld;
    logic [15:0] exp;
    logic [15:0] rx;
    int n;
    int d0;
    int ea;
    vld = 1'b0;
    exp = 16'h0000;
    ea = 0;
    if (ch < 3) begin
      if (idx < mq[ch].size()) begin
        vld = 1'b1;
        exp = mq[ch][idx];
        ea = BASE + ch * DEPTH
           + ((wcnt[ch] - mq[ch].size() + idx) % DEPTH);
      end
    end
    rd_ch = 2'(ch);
    rd_idx = 4'(idx);
    rd_req = 1'b1;
    if (with_adc) begin
      adc_valid = 1'b1;
      adc_ch = 2'd1;
      adc_data = 8'h77;
      time_stamp = 8'h01;
    end
    d0 = done_cnt;
    @(posedge clk); #1;
    n = 0;
    while (!rd_busy && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rd_accept", rd_busy, 1);
    rd_req = 1'b0;
    if (with_adc) begin
      chk("rd_first_ready", adc_ready, 0);
      chk("rd_first_we", WE, 0);
      adc_valid = 1'b0;
    end
    chk("rd_empty", rd_empty, !vld);
    chk("rd_t1_pcb", PC_B, !vld);
    if (vld) chk("rd_addr", mem_address, ea);
    @(posedge clk); #1;
    chk("rd_t2_se", SE, vld);
    if (vld) begin
      @(posedge clk); #1;
    end
    rx = '0;
    for (int k = 0; k < 16; k++) begin
      rx = {rx[14:0], bit_out};
      bit_clk = 1'b1;
      if (k < 15) begin
        repeat (3) @(posedge clk);
        #1;
      end else begin
        n = 0;
        while (!rd_done && n < 6) begin
          @(posedge clk); #1;
          n++;
        end
        chk("rd_done_seen", rd_done, 1);
        chk("rd_busy_at_done", rd_busy, 0);
      end
      bit_clk = 1'b0;
      repeat (3) @(posedge clk);
      #1;
    end
    chk("rd_bits", rx, exp);
    chk("rd_done_count", done_cnt - d0, 1);
    chk("rd_busy_end", rd_busy, 0);
    if (POP && vld && idx == 0) void'(mq[ch].pop_front());
    got = rx;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] g, g1, g2;
    int d0;
    for (int a = 0; a < 64; a++) mem[a] = 16'h0000;
    model_clear();
    reset = 1'b0;
    adc_valid = 1'b0;
    adc_ch = '0;
    adc_data = '0;
    time_stamp = '0;
    rd_req = 1'b0;
    rd_ch = '0;
    rd_idx = '0;
    bit_clk = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pcb", PC_B, 1);
    chk("rst_we_se", {WE, SE}, 0);
    chk("rst_addr", mem_address, 0);
    chk("rst_data", mem_data_out, 0);
    chk("rst_flags", {bit_out, rd_busy, rd_done, rd_empty}, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_ready_low", adc_ready, 0);
    reset = 1'b1;
    #1;
    chk("rst_ready_high", adc_ready, 1);
    @(posedge clk); #1;
    chk_en = 1'b1;

    do_write(1, 8'hA5, 8'h3C);
    chk("w1_mem", mem[32], 16'h3CA5);

    do_write(2, 8'h0F, 8'hB0);
    do_read(2, 0, 1'b0, g);
    chk("r_b00f", g, 16'hB00F);

    for (int i = 0; i < 17; i++) do_write(0, 8'(i), 8'(8'h10 + i));
    chk("w17_addr", mem_address, 16);
    chk("w17_ovf", ovf, 3'b001);
    do_read(0, 0, 1'b0, g);
    chk("r_second", g, 16'h1101);

    do_write(1, 8'h5A, 8'h01);
    do_read(1, 5, 1'b0, g);
    chk("r_inv_bits", g, 16'h0000);
    chk("r_inv_empty", rd_empty, 1);
    do_write(3, 8'hEE, 8'hEE);
    chk("empty_held", rd_empty, 1);

    d0 = done_cnt;
    repeat (3) begin
      bit_clk = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      bit_clk = 1'b0;
      repeat (2) @(posedge clk);
      #1;
    end
    chk("idle_bclk_done", done_cnt - d0, 0);
    chk("idle_bclk_busy", rd_busy, 0);

    do_read(1, 0, 1'b1, g);
    chk("r_first_val", g, 16'h3CA5);
    chk("empty_cleared", rd_empty, 0);

    adc_ch = 2'd0;
    adc_data = 8'hEE;
    time_stamp = 8'hEE;
    adc_valid = 1'b1;
    @(posedge clk); #1;
    adc_valid = 1'b0;
    chk("abort_in_pre", PC_B, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    model_clear();
    chk("abort_pcb", PC_B, 1);
    chk("abort_we", WE, 0);
    chk("abort_addr", mem_address, 0);
    chk("abort_ovf", ovf, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    do_write(0, 8'h42, 8'h24);
    chk("abort_ptr0", mem_address, 16);

    do_write(2, 8'h11, 8'hAA);
    do_write(2, 8'h22, 8'hBB);
    do_read(2, 0, 1'b0, g1);
    do_read(2, 0, 1'b0, g2);
`ifdef SENSLOG_POP_ON_READ_EN
    chk("pop_first", g1, 16'hAA11);
    chk("pop_second", g2, 16'hBB22);
    do_read(2, 0, 1'b0, g);
`else
    chk("keep_first", g1, 16'hAA11);
    chk("keep_again", g2, 16'hAA11);
    do_read(2, 2, 1'b0, g);
`endif
    chk("third_empty", rd_empty, 1);
    chk("third_bits", g, 16'h0000);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
